// File: rtl/ex_muldiv_sequencer_if.sv
// rtl/ex_muldiv_sequencer_if.sv - EX-stage multiply/divide sequencer bus
//
// Purpose: groups the request/response signals between the EX stage and the
// multi-cycle M-extension sequencer.
// Signals:
//   start_in, funct3_in, operand_a_in, operand_b_in, flush_in  (EX -> seq)
//   stall_out, busy_out, result_out, result_valid_out           (seq -> EX)
// Modports: master (EX stage side), slave (sequencer side).
interface ex_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_in;
  logic [2:0]       funct3_in;
  logic [WIDTH-1:0] operand_a_in;
  logic [WIDTH-1:0] operand_b_in;
  logic             flush_in;
  logic             stall_out;
  logic             busy_out;
  logic [WIDTH-1:0] result_out;
  logic             result_valid_out;

  modport master (
    output start_in, funct3_in, operand_a_in, operand_b_in, flush_in,
    input  stall_out, busy_out, result_out, result_valid_out
  );

  modport slave (
    input  start_in, funct3_in, operand_a_in, operand_b_in, flush_in,
    output stall_out, busy_out, result_out, result_valid_out
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// rtl/ex_muldiv_sequencer.sv - fixed-latency RV32 M-extension multiply/divide sequencer
//
// Purpose: accepts one MUL/DIV-family op from EX, runs WIDTH shift-add or
// restoring-subtract steps, applies sign/selection fixup, then strobes the
// result. Latency from accept to result_valid_out is always WIDTH+2 cycles.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-low reset
//   bus    - ex_muldiv_sequencer_if.slave (start/funct3/operands/flush in,
//            stall/busy/result/result_valid out)
// Configuration: MULDIV_SIGNED_EN enables signed MULH/MULHSU/DIV/REM; when
// undefined those ops execute as their unsigned counterparts.
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  ex_muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] b_q, b_d;         // multiplicand or divisor magnitude
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef MULDIV_SIGNED_EN
  logic             neg_q, neg_d;     // negate product / quotient in FIX
  logic             neg_rem_q, neg_rem_d;
  logic             a_signed, b_signed, a_neg, b_neg;
`endif

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;
  logic               stall, valid;

  // One datapath step: add-then-shift-right for multiply, shift-left-then-
  // trial-subtract for divide. Divisor 0 always "fits", giving all-ones/dividend.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    mag_a = bus.operand_a_in;
    mag_b = bus.operand_b_in;
`ifdef MULDIV_SIGNED_EN
    a_signed = bus.funct3_in[2] ? ~bus.funct3_in[0]
                                : (bus.funct3_in[1:0] == 2'b01 || bus.funct3_in[1:0] == 2'b10);
    b_signed = bus.funct3_in[2] ? ~bus.funct3_in[0] : (bus.funct3_in[1:0] == 2'b01);
    a_neg    = a_signed & bus.operand_a_in[WIDTH-1];
    b_neg    = b_signed & bus.operand_b_in[WIDTH-1];
    if (a_neg) mag_a = -bus.operand_a_in;
    if (b_neg) mag_b = -bus.operand_b_in;
`endif
  end

  // FIX-stage selection of high/low product or quotient/remainder.
  always_comb begin
    prod = {hi_q, lo_q};
    quo  = lo_q;
    rem  = hi_q;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -{hi_q, lo_q};
      quo  = -lo_q;
    end
    if (neg_rem_q) rem = -hi_q;
`endif
    if (funct3_q[2])                fix_res = funct3_q[1] ? rem : quo;
    else if (funct3_q[1:0] == 2'b00) fix_res = prod[WIDTH-1:0];
    else                            fix_res = prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    funct3_d = funct3_q;
    result_d = result_q;
`ifdef MULDIV_SIGNED_EN
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
`endif
    stall = 1'b0;
    valid = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.start_in & ~bus.flush_in;
        if (bus.start_in && !bus.flush_in) begin
          state_d  = CALC;
          cnt_d    = '0;
          funct3_d = bus.funct3_in;
          hi_d     = '0;
          lo_d     = bus.funct3_in[2] ? mag_a : mag_b;
          b_d      = bus.funct3_in[2] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
          // Divide-by-zero keeps the all-ones quotient unsigned-looking.
          neg_d     = (a_neg ^ b_neg) & (~bus.funct3_in[2] | (bus.operand_b_in != '0));
          neg_rem_d = a_neg;
`endif
        end
      end
      CALC: begin
        stall = 1'b1;
        if (funct3_q[2]) begin
          hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        stall    = 1'b1;
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        valid   = ~bus.flush_in;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_in) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      funct3_q  <= '0;
      result_q  <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      funct3_q  <= funct3_d;
      result_q  <= result_d;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign bus.stall_out        = stall & reset;
  assign bus.result_valid_out = valid & reset;
  assign bus.busy_out         = (state_q != IDLE);
  assign bus.result_out       = result_q;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb/tb_ex_muldiv_sequencer.sv - self-checking bench for ex_muldiv_sequencer
module tb_ex_muldiv_sequencer;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  ex_muldiv_sequencer_if #(.WIDTH(32)) bus ();
  ex_muldiv_sequencer #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;
  always @(posedge clock) cyc_g <= cyc_g + 1;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] es;
    logic [31:0] eu;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] es, input logic [31:0] eu);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.es = es; v.eu = eu;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %0s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, output int t_start, output int t_valid);
    logic prof_ok;
    bus.start_in     = 1'b1;
    bus.funct3_in    = f;
    bus.operand_a_in = a;
    bus.operand_b_in = b;
    exp_q.push_back(expv);
    t_start = cyc_g;
    t_valid = -1;
    prof_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (bus.result_valid_out) begin
        t_valid = cyc_g;
        check("done_stall", 32'(bus.stall_out), 32'd0);
        check("done_busy", 32'(bus.busy_out), 32'd1);
        check($sformatf("result f=%b a=%h b=%h", f, a, b), bus.result_out, exp_q.pop_front());
        tick();
        break;
      end
      if (!bus.stall_out || (bus.busy_out !== (c != 0))) prof_ok = 1'b0;
      tick();
    end
    if (t_valid < 0) void'(exp_q.pop_front());
    check("latency", 32'(t_valid - t_start), 32'd34);
    check("stall_busy_profile", 32'(prof_ok), 32'd1);
  endtask

  task automatic idle();
    bus.start_in = 1'b0;
    tick();
  endtask

  initial begin
    int ts1, tv1, ts2, tv2;
    logic seen;
    bus.start_in     = 1'b0;
    bus.flush_in     = 1'b0;
    bus.funct3_in    = 3'b000;
    bus.operand_a_in = '0;
    bus.operand_b_in = '0;

    add(3'b000, 32'd7,        32'd6,        32'd42,       32'd42);
    add(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE);
    add(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE);
    add(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h00000001);
    add(3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF);
    add(3'b111, 32'd100,      32'd0,        32'd100,      32'd100);
    add(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    add(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    add(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'h7FFFFFFC);
    add(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'h00000001);
    add(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    add(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFF1);
    add(3'b011, 32'h80000000, 32'd4,        32'h00000002, 32'h00000002);
    add(3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'h00000002);
    add(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF);
    add(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFB);
    add(3'b101, 32'd1000,     32'd7,        32'd142,      32'd142);
    add(3'b111, 32'd1000,     32'd7,        32'd6,        32'd6);

    // Reset held: stall must stay low even with start asserted.
    tick(); tick();
    bus.start_in = 1'b1;
    @(negedge clock);
    check("reset_stall", 32'(bus.stall_out), 32'd0);
    tick();
    bus.start_in = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_valid", 32'(bus.result_valid_out), 32'd0);
    check("rst_result", bus.result_out, 32'd0);
    check("rst_stall_idle", 32'(bus.stall_out), 32'd0);
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, SIGNED ? vecs[i].es : vecs[i].eu, ts1, tv1);
      idle();
    end

    // Flush at CALC step 10 (cycle 11 after accept).
    do_op(3'b000, 32'd7, 32'd6, 32'd42, ts1, tv1);
    idle();
    bus.start_in = 1'b1; bus.funct3_in = 3'b101;
    bus.operand_a_in = 32'd1000; bus.operand_b_in = 32'd10;
    for (int c = 0; c < 11; c++) tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    bus.start_in = 1'b0;
    @(negedge clock);
    check("flush_busy", 32'(bus.busy_out), 32'd0);
    check("flush_stall", 32'(bus.stall_out), 32'd0);
    check("flush_valid", 32'(bus.result_valid_out), 32'd0);
    check("flush_result", bus.result_out, 32'd42);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clock);
      if (bus.result_valid_out) seen = 1'b1;
    end
    check("flush_no_strobe", 32'(seen), 32'd0);
    check("flush_result_hold", bus.result_out, 32'd42);
    tick();

    // Flush beats a same-cycle start in IDLE.
    bus.start_in = 1'b1; bus.flush_in = 1'b1;
    @(negedge clock);
    check("flush_prio_stall", 32'(bus.stall_out), 32'd0);
    tick();
    bus.start_in = 1'b0; bus.flush_in = 1'b0;
    @(negedge clock);
    check("flush_prio_busy", 32'(bus.busy_out), 32'd0);
    tick();

    // Reset at CALC step 20.
    bus.start_in = 1'b1; bus.funct3_in = 3'b101;
    bus.operand_a_in = 32'd9; bus.operand_b_in = 32'd4;
    for (int c = 0; c < 21; c++) tick();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_stall", 32'(bus.stall_out), 32'd0);
    tick();
    @(negedge clock);
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_valid", 32'(bus.result_valid_out), 32'd0);
    check("midrst_result", bus.result_out, 32'd0);
    check("midrst_stall2", 32'(bus.stall_out), 32'd0);
    tick();
    reset = 1'b1;
    bus.start_in = 1'b0;
    tick();

    // Back-to-back divides with start held continuously.
    do_op(3'b101, 32'd1000, 32'd10, 32'd100, ts1, tv1);
    do_op(3'b101, 32'd9,    32'd4,  32'd2,   ts2, tv2);
    idle();
    check("b2b_first_valid", 32'(tv1 - ts1), 32'd34);
    check("b2b_second_valid", 32'(tv2 - ts1), 32'd69);
    check("b2b_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_sequencer.md
EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start_in, input, 1, high while EX holds a valid M-extension R-type instruction.
REQ-005 The block SHALL have port funct3_in, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports operand_a_in and operand_b_in, input, WIDTH each, post-forwarding rs1/rs2 values.
REQ-007 The block SHALL have port flush_in, input, 1, abort request from branch resolution.
REQ-008 The block SHALL have port stall_out, output, 1, hold PC, IF/ID and ID/EX and insert a bubble into EX/MEM.
REQ-009 The block SHALL have ports busy_out, output, 1, operation in progress; result_out, output, WIDTH, final result; result_valid_out, output, 1, single-cycle result strobe.

Function
REQ-010 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-011 IDLE: start_in=1 and flush_in=0 SHALL latch operands and funct3, clear the step counter and go to CALC; stall_out SHALL equal start_in & ~flush_in combinationally in IDLE.
REQ-012 CALC SHALL do one shift-add (multiply) or restoring-subtract (divide) step per cycle for exactly WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
REQ-013 FIX SHALL apply sign correction and high/low or quotient/remainder selection for one cycle, register result_out, then go to DONE.
REQ-014 DONE SHALL drive stall_out=0 and result_valid_out=1 for exactly one cycle, ignore start_in, and go to IDLE.
REQ-015 Latency SHALL be fixed: start accepted in cycle 0 gives result_valid_out in cycle WIDTH+2 (34), with stall_out=1 in cycles 0..WIDTH+1, for every operand value.
REQ-016 busy_out SHALL be 1 in CALC, FIX and DONE, 0 in IDLE.
REQ-017 result_out SHALL hold its value from DONE until the next FIX or reset.
REQ-018 MUL SHALL return product bits [31:0]; MULH/MULHSU/MULHU SHALL return bits [63:32] with the operand signedness of the RISC-V M extension.
REQ-019 Division by zero SHALL give quotient 0xFFFFFFFF (DIV, DIVU) and remainder = operand_a (REM, REMU).
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0.
REQ-021 flush_in=1 in any state SHALL force IDLE on the next edge with no result_valid_out pulse and result_out unchanged; flush_in has priority over a same-cycle start_in.
REQ-022 A new start_in in the cycle after DONE SHALL be accepted, so back-to-back operations have one non-stalled cycle between them.

Reset
REQ-023 With reset=0 at an edge, the block SHALL enter IDLE and clear the counter, result_out, result_valid_out, busy_out and the latched operands, from any state including mid-CALC.
REQ-024 While in reset, stall_out SHALL be 0 regardless of start_in.

Configuration
REQ-025 Macro MULDIV_SIGNED_EN defined: all eight funct3 ops SHALL be supported with signed handling per REQ-018 to REQ-020.
REQ-026 Macro MULDIV_SIGNED_EN undefined: no sign-correction logic SHALL exist; MULH and MULHSU SHALL execute as MULHU, DIV as DIVU and REM as REMU, with identical latency.

Verification
REQ-027 MUL, a=7, b=6: stall_out=1 for cycles 0..33; cycle 34 result_valid_out=1, result_out=42, stall_out=0.
REQ-028 MULH (signed build), a=0xFFFFFFFF, b=0xFFFFFFFF: result_out=0x00000000; MULHU with the same operands: 0xFFFFFFFE.
REQ-029 DIVU, a=100, b=0: result 0xFFFFFFFF; REMU with the same operands: 100; DIV, a=0x80000000, b=0xFFFFFFFF: result 0x80000000.
REQ-030 DIV, a=-7, b=2: result 0xFFFFFFFD; REM with the same operands: 0xFFFFFFFF; unsigned-only build gives DIVU semantics 0x7FFFFFFC.
REQ-031 flush_in pulsed at CALC step 10: IDLE next cycle, stall_out=0, no result_valid_out, result_out holds its prior value; reset=0 at step 20 of a later operation clears all outputs to 0.
REQ-032 Two back-to-back DIVU ops (1000/10, then 9/4): result_valid_out in cycles 34 and 69, results 100 and 2, stall_out=0 only in cycles 34 and 69 between the two operations.
